// File: rtl/mvm_uart_ctrl_if.sv
// Bundle of RX, engine and TX handshake signals around the frame sequencer.
// slave = controller side, master = surrounding environment (UART + engine).
interface mvm_uart_ctrl_if #(
    parameter int BITS_PER_WORD = 8,
    parameter int R             = 2,
    parameter int C             = 2,
    parameter int W_K           = 4,
    parameter int W_X           = 4,
    parameter int W_Y_OUT       = 8
);
    logic [BITS_PER_WORD-1:0] s_data;
    logic                     s_valid;
    logic                     s_ready;
    logic [R*C*W_K-1:0]       k_flat;
    logic [C*W_X-1:0]         x_flat;
    logic                     mvm_valid;
    logic                     mvm_ready;
    logic                     y_valid;
    logic [R*W_Y_OUT-1:0]     y_flat;
    logic [BITS_PER_WORD-1:0] m_data;
    logic                     m_valid;
    logic                     m_ready;
    logic                     busy;

    modport slave (
        input  s_data, s_valid, mvm_ready, y_valid, y_flat, m_ready,
        output s_ready, k_flat, x_flat, mvm_valid, m_data, m_valid, busy
    );

    modport master (
        output s_data, s_valid, mvm_ready, y_valid, y_flat, m_ready,
        input  s_ready, k_flat, x_flat, mvm_valid, m_data, m_valid, busy
    );
endinterface

// File: rtl/mvm_uart_ctrl.sv
// Frame sequencer: RX bytes -> K/X registers -> MVM engine -> result bytes on TX.
// Latency: mvm_valid one cycle after last RX byte; m_valid one cycle after y_valid.
// Backpressure: s_ready low outside LOAD; mvm_valid/m_valid held with stable data until ready.
module mvm_uart_ctrl #(
    parameter int BITS_PER_WORD = 8,
    parameter int R             = 2,
    parameter int C             = 2,
    parameter int W_K           = 4,
    parameter int W_X           = 4,
    parameter int W_Y_OUT       = 8
) (
    input  logic          clk,
    input  logic          rst,
    mvm_uart_ctrl_if.slave bus
);
    localparam int N_K     = R * C;
    localparam int N_BYTES = R * C + C;
    localparam int CNT_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam int ROW_W   = (R > 1) ? $clog2(R) : 1;

    typedef enum logic [1:0] {LOAD, HANDOFF, WAIT, SEND} state_t;

    state_t                   state, state_nxt;
    logic [CNT_W-1:0]         cnt;
    logic [ROW_W-1:0]         row;
    logic [W_K-1:0]           k_reg [N_K];
    logic [W_X-1:0]           x_reg [C];
    logic [W_Y_OUT-1:0]       y_reg [R];
    logic                     s_ready, mvm_valid, m_valid;
    logic                     rx_fire, tx_fire, last_byte, last_row;
    logic [BITS_PER_WORD-1:0] tx_byte;
    logic [R*C*W_K-1:0]       k_flat;
    logic [C*W_X-1:0]         x_flat;

    assign last_byte = (cnt == CNT_W'(N_BYTES - 1));
    assign last_row  = (row == ROW_W'(R - 1));
    assign rx_fire   = s_ready && bus.s_valid;
    assign tx_fire   = m_valid && bus.m_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LOAD;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        mvm_valid = 1'b0;
        m_valid   = 1'b0;
        case (state)
            LOAD: begin
                s_ready = 1'b1;
                if (bus.s_valid && last_byte) state_nxt = HANDOFF;
            end
            HANDOFF: begin
                mvm_valid = 1'b1;
                if (bus.mvm_ready) state_nxt = WAIT;
            end
            WAIT: begin
                if (bus.y_valid) state_nxt = SEND;
            end
            SEND: begin
                m_valid = 1'b1;
                if (bus.m_ready && last_row) state_nxt = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            row <= '0;
        end else begin
            if (rx_fire) cnt <= last_byte ? '0 : cnt + 1'b1;
            if (tx_fire) row <= last_row ? '0 : row + 1'b1;
        end
    end

    // Byte position selects the destination; bits above the element width are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < N_K; n++) k_reg[n] <= '0;
            for (int j = 0; j < C; j++)   x_reg[j] <= '0;
            for (int r = 0; r < R; r++)   y_reg[r] <= '0;
        end else begin
            if (rx_fire) begin
                for (int n = 0; n < N_K; n++)
                    if (cnt == CNT_W'(n)) k_reg[n] <= bus.s_data[W_K-1:0];
                for (int j = 0; j < C; j++)
                    if (cnt == CNT_W'(N_K + j)) x_reg[j] <= bus.s_data[W_X-1:0];
            end
            if (state == WAIT && bus.y_valid) begin
                for (int r = 0; r < R; r++)
                    y_reg[r] <= bus.y_flat[r*W_Y_OUT +: W_Y_OUT];
            end
        end
    end

    always_comb begin
        tx_byte = '0;
        for (int r = 0; r < R; r++)
            if (row == ROW_W'(r)) tx_byte = BITS_PER_WORD'(y_reg[r]);
    end

    always_comb begin
        k_flat = '0;
        x_flat = '0;
        for (int n = 0; n < N_K; n++) k_flat[n*W_K +: W_K] = k_reg[n];
        for (int j = 0; j < C; j++)   x_flat[j*W_X +: W_X] = x_reg[j];
    end

    assign bus.s_ready   = s_ready;
    assign bus.mvm_valid = mvm_valid;
    assign bus.m_valid   = m_valid;
    assign bus.m_data    = tx_byte;
    assign bus.k_flat    = k_flat;
    assign bus.x_flat    = x_flat;
    assign bus.busy      = (state != LOAD) || (cnt != '0);
endmodule

// File: tb/tb_mvm_uart_ctrl.sv
// Randomized frame-level bench for mvm_uart_ctrl with a queue/arithmetic reference model.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_mvm_uart_ctrl;
    localparam int BPW = 8, R = 2, C = 2, W_K = 4, W_X = 4, W_Y = 8;
    localparam int NK = R * C, NB = R * C + C;

    typedef logic [7:0] frame_t [NB];

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mvm_uart_ctrl_if #(.BITS_PER_WORD(BPW), .R(R), .C(C), .W_K(W_K), .W_X(W_X), .W_Y_OUT(W_Y)) bus ();

    mvm_uart_ctrl #(.BITS_PER_WORD(BPW), .R(R), .C(C), .W_K(W_K), .W_X(W_X), .W_Y_OUT(W_Y)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [R*C*W_K-1:0] kexp;
    logic [C*W_X-1:0]   xexp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Reference: K element n is byte n masked to W_K, X element j is byte NK+j masked to W_X.
    task automatic set_model(input frame_t b);
        for (int n = 0; n < NK; n++) kexp[n*W_K +: W_K] = b[n][W_K-1:0];
        for (int j = 0; j < C; j++)  xexp[j*W_X +: W_X] = b[NK+j][W_X-1:0];
    endtask

    task automatic send_bytes(input frame_t b, input int first, input int last);
        for (int n = first; n <= last; n++) begin
            int g = 0;
            bus.s_data  = b[n];
            bus.s_valid = 1'b1;
            while (!bus.s_ready && g < 100) begin
                step();
                g++;
            end
            check("rx_ready", {31'd0, bus.s_ready}, 32'd1);
            check("no_early_mvm", {31'd0, bus.mvm_valid}, 32'd0);
            step();
        end
    endtask

    task automatic run_frame(input frame_t b, input int stall, input logic [15:0] y, input int mode,
                             input bit hold, input logic [7:0] hold_byte, input bit stray_y,
                             input bit rst_send);
        logic [7:0] got[$];
        logic [7:0] prev_dat;
        bit         prev_stall;
        int         hcnt, g, wc, ph;
        set_model(b);
        send_bytes(b, 0, NB - 1);
        if (hold) bus.s_data = hold_byte;
        else      bus.s_valid = 1'b0;
        check("mvm_rise", {31'd0, bus.mvm_valid}, 32'd1);
        check("k_flat", {16'd0, bus.k_flat}, {16'd0, kexp});
        check("x_flat", {24'd0, bus.x_flat}, {24'd0, xexp});
        check("busy_frame", {31'd0, bus.busy}, 32'd1);

        hcnt = 0;
        g    = 0;
        while (bus.mvm_valid && g < 50) begin
            hcnt++;
            g++;
            bus.mvm_ready = (hcnt >= stall + 1);
            if (stray_y && stall > 0 && hcnt == 1) begin
                bus.y_valid = 1'b1;
                bus.y_flat  = ~y;
            end
            check("handoff_s_ready", {31'd0, bus.s_ready}, 32'd0);
            step();
            bus.y_valid = 1'b0;
            check("kx_hold_handoff", {bus.k_flat, bus.x_flat}, {kexp, xexp});
        end
        bus.mvm_ready = 1'b0;
        check("mvm_hold", hcnt, stall + 1);
        check("mvm_drop", {31'd0, bus.mvm_valid}, 32'd0);

        wc = stray_y ? 1 + $urandom_range(0, 2) : $urandom_range(0, 3);
        repeat (wc) begin
            check("wait_idle", {29'd0, bus.mvm_valid, bus.m_valid, bus.s_ready}, 32'd0);
            check("wait_busy", {31'd0, bus.busy}, 32'd1);
            step();
        end

        bus.y_flat  = y;
        bus.y_valid = 1'b1;
        step();
        bus.y_valid = 1'b0;
        bus.y_flat  = 16'($urandom);
        check("tx_rise", {31'd0, bus.m_valid}, 32'd1);

        prev_stall = 1'b0;
        prev_dat   = '0;
        ph         = 0;
        g          = 0;
        while (got.size() < R && g < 100) begin
            case (mode)
                0:       bus.m_ready = 1'b1;
                1:       bus.m_ready = (ph % 2 == 0);
                default: bus.m_ready = 1'($urandom_range(0, 1));
            endcase
            check("tx_valid", {31'd0, bus.m_valid}, 32'd1);
            check("send_s_ready", {31'd0, bus.s_ready}, 32'd0);
            check("kx_hold_send", {bus.k_flat, bus.x_flat}, {kexp, xexp});
            if (prev_stall) check("tx_stable", {24'd0, bus.m_data}, {24'd0, prev_dat});
            if (bus.m_ready && bus.m_valid) begin
                got.push_back(bus.m_data);
                if (rst_send && got.size() == 1) begin
                    @(posedge clk);
                    #2;
                    rst = 1'b1;
                    #1;
                    check("rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
                    check("rst_busy", {31'd0, bus.busy}, 32'd0);
                    check("rst_kx", {bus.k_flat, bus.x_flat}, 32'd0);
                    @(negedge clk);
                    rst = 1'b0;
                    step();
                    repeat (4) begin
                        bus.m_ready = 1'b1;
                        check("no_second_byte", {31'd0, bus.m_valid}, 32'd0);
                        step();
                    end
                    bus.m_ready = 1'b0;
                    check("rst_first_byte", {24'd0, got[0]}, {24'd0, y[7:0]});
                    return;
                end
            end
            prev_stall = !bus.m_ready;
            prev_dat   = bus.m_data;
            ph++;
            g++;
            step();
        end
        bus.m_ready = 1'b0;
        check("tx_count", got.size(), R);
        for (int r = 0; r < R; r++)
            if (r < got.size()) check("tx_byte", {24'd0, got[r]}, {24'd0, y[r*W_Y +: W_Y]});
        check("end_s_ready", {31'd0, bus.s_ready}, 32'd1);
        check("end_busy", {31'd0, bus.busy}, 32'd0);
        check("end_m_valid", {31'd0, bus.m_valid}, 32'd0);
    endtask

    task automatic rand_frame(output frame_t f);
        for (int n = 0; n < NB; n++) f[n] = 8'($urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        frame_t     f, f2;
        logic [7:0] nb0;
        bit         prev_hold, hold;
        bus.s_data = '0; bus.s_valid = 1'b0; bus.mvm_ready = 1'b0;
        bus.y_valid = 1'b0; bus.y_flat = '0; bus.m_ready = 1'b0;

        rst = 1'b1;
        repeat (2) step();
        @(negedge clk);
        rst = 1'b0;
        step();
        check("rst_s_ready", {31'd0, bus.s_ready}, 32'd1);
        check("rst_mvm_valid", {31'd0, bus.mvm_valid}, 32'd0);
        check("rst_m_valid0", {31'd0, bus.m_valid}, 32'd0);
        check("rst_m_data", {24'd0, bus.m_data}, 32'd0);
        check("rst_busy0", {31'd0, bus.busy}, 32'd0);
        check("rst_kx0", {bus.k_flat, bus.x_flat}, 32'd0);

        f = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        run_frame(f, 0, 16'h2711, 0, 1'b0, 8'h00, 1'b0, 1'b0);
        check("nominal_k", {16'd0, bus.k_flat}, 32'h4321);
        check("nominal_x", {24'd0, bus.x_flat}, 32'h65);

        bus.y_flat  = 16'hBEEF;
        bus.y_valid = 1'b1;
        step();
        bus.y_valid = 1'b0;
        repeat (3) begin
            check("stray_y_load", {30'd0, bus.m_valid, bus.busy}, 32'd0);
            step();
        end

        f = '{8'hF1, 8'hA2, 8'h33, 8'hC4, 8'hE5, 8'h96};
        run_frame(f, 5, 16'h2711, 1, 1'b0, 8'h00, 1'b1, 1'b0);
        check("mask_k", {16'd0, bus.k_flat}, 32'h4321);
        check("mask_x", {24'd0, bus.x_flat}, 32'h65);

        rand_frame(f);
        set_model(f);
        send_bytes(f, 0, 2);
        bus.s_valid = 1'b0;
        check("busy_partial", {31'd0, bus.busy}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_kx", {bus.k_flat, bus.x_flat}, 32'd0);
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        rand_frame(f);
        run_frame(f, 1, 16'($urandom), 2, 1'b0, 8'h00, 1'b0, 1'b0);

        rand_frame(f);
        run_frame(f, 0, 16'($urandom), 0, 1'b0, 8'h00, 1'b0, 1'b1);

        rand_frame(f);
        rand_frame(f2);
        run_frame(f, 2, 16'($urandom), 0, 1'b1, f2[0], 1'b0, 1'b0);
        run_frame(f2, 0, 16'($urandom), 1, 1'b0, 8'h00, 1'b0, 1'b0);

        prev_hold = 1'b0;
        nb0       = 8'($urandom);
        for (int i = 0; i < 8; i++) begin
            rand_frame(f);
            if (prev_hold) f[0] = nb0;
            hold = (i < 7) ? 1'($urandom_range(0, 1)) : 1'b0;
            nb0  = 8'($urandom);
            run_frame(f, $urandom_range(0, 5), 16'($urandom), $urandom_range(0, 2),
                      hold, nb0, 1'($urandom_range(0, 1)), 1'b0);
            prev_hold = hold;
        end

        repeat (2) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
